// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter: owns the SDRAM command/address bus and shares it
// between the init, auto-refresh, write and read engines. Keeps the refresh
// interval timer, grants one engine at a time (refresh first) and muxes the
// granted engine's command/address/bank onto the pins.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating write/read
// arbitration on ties; otherwise read has fixed priority over write.
module sdram_access_arbiter #(
  parameter int SDRAM_ADDR_WIDTH = 12,
  parameter int SDRAM_BANK_WIDTH = 2,
  parameter int REF_PERIOD       = 780
) (
  input  logic                        Sys_clk,
  input  logic                        Rst,
  input  logic                        Init_done,
  input  logic [3:0]                  Init_cmd,
  input  logic [SDRAM_ADDR_WIDTH-1:0] Init_addr,
  input  logic                        Aref_end,
  input  logic [3:0]                  Aref_cmd,
  input  logic                        Wr_req,
  input  logic                        Rd_req,
  input  logic                        Wr_end,
  input  logic                        Rd_end,
  input  logic [3:0]                  Wr_cmd,
  input  logic [3:0]                  Rd_cmd,
  input  logic [SDRAM_ADDR_WIDTH-1:0] Wr_addr,
  input  logic [SDRAM_ADDR_WIDTH-1:0] Rd_addr,
  input  logic [SDRAM_BANK_WIDTH-1:0] Wr_bank,
  input  logic [SDRAM_BANK_WIDTH-1:0] Rd_bank,
  output logic                        Aref_en,
  output logic                        Wr_en,
  output logic                        Rd_en,
  output logic [3:0]                  SDRAM_CMD,
  output logic [SDRAM_ADDR_WIDTH-1:0] SDRAM_A_ADDR,
  output logic [SDRAM_BANK_WIDTH-1:0] SDRAM_BANK_ADDR,
  output logic                        Aref_overrun
);

  localparam int TIMER_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {INIT, IDLE, AREF, WRITE, READ} state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               aref_pending;
  logic               timer_run;
  logic               timer_expire;
  logic               pick_wr;
  logic               pick_rd;
`ifdef ARB_ROUND_ROBIN_EN
  logic               last_wr;
`endif

  // Timer runs in every non-INIT state and also on the edge that sees
  // Init_done, so the first expiry lands REF_PERIOD cycles after Init_done.
  always_comb begin
    timer_run    = (state != INIT) || Init_done;
    timer_expire = timer_run && (timer == TIMER_W'(REF_PERIOD - 1));
  end

  // Write/read arbitration among simultaneous requests.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_wr = Wr_req && (!Rd_req || !last_wr);
    pick_rd = Rd_req && !pick_wr;
`else
    pick_rd = Rd_req;
    pick_wr = Wr_req && !Rd_req;
`endif
  end

  // Grant FSM with refresh timer, pending/overrun flags and registered grants.
  always_ff @(posedge Sys_clk) begin
    if (Rst) begin
      state        <= INIT;
      Aref_en      <= 1'b0;
      Wr_en        <= 1'b0;
      Rd_en        <= 1'b0;
      timer        <= '0;
      aref_pending <= 1'b0;
      Aref_overrun <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_wr      <= 1'b0;
`endif
    end else begin
      if (timer_run)
        timer <= timer_expire ? '0 : timer + 1'b1;

      // A fresh expiry wins over the clear on AREF entry.
      if (timer_expire) begin
        aref_pending <= 1'b1;
        if (aref_pending)
          Aref_overrun <= 1'b1;
      end else if (state == IDLE && aref_pending) begin
        aref_pending <= 1'b0;
      end

      case (state)
        INIT: begin
          if (Init_done)
            state <= IDLE;
        end
        IDLE: begin
          if (aref_pending) begin
            state   <= AREF;
            Aref_en <= 1'b1;
          end else if (pick_wr) begin
            state <= WRITE;
            Wr_en <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_wr <= 1'b1;
`endif
          end else if (pick_rd) begin
            state <= READ;
            Rd_en <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_wr <= 1'b0;
`endif
          end
        end
        AREF: begin
          if (Aref_end) begin
            state   <= IDLE;
            Aref_en <= 1'b0;
          end
        end
        WRITE: begin
          if (Wr_end) begin
            state <= IDLE;
            Wr_en <= 1'b0;
          end
        end
        READ: begin
          if (Rd_end) begin
            state <= IDLE;
            Rd_en <= 1'b0;
          end
        end
        default: begin
          state   <= INIT;
          Aref_en <= 1'b0;
          Wr_en   <= 1'b0;
          Rd_en   <= 1'b0;
        end
      endcase
    end
  end

  // Pin mux driven straight from the registered state (no added latency).
  always_comb begin
    SDRAM_CMD       = CMD_NOP;
    SDRAM_A_ADDR    = '0;
    SDRAM_BANK_ADDR = '0;
    case (state)
      INIT: begin
        SDRAM_CMD    = Init_cmd;
        SDRAM_A_ADDR = Init_addr;
      end
      AREF: begin
        SDRAM_CMD = Aref_cmd;
      end
      WRITE: begin
        SDRAM_CMD       = Wr_cmd;
        SDRAM_A_ADDR    = Wr_addr;
        SDRAM_BANK_ADDR = Wr_bank;
      end
      READ: begin
        SDRAM_CMD       = Rd_cmd;
        SDRAM_A_ADDR    = Rd_addr;
        SDRAM_BANK_ADDR = Rd_bank;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb_sdram_access_arbiter: directed scenarios plus randomized traffic,
// every cycle checked against a behavioural model of the arbiter.
module tb_sdram_access_arbiter;

  localparam int AW = 12;
  localparam int BW = 2;
  localparam int RP = 780;

  localparam int O_INIT = 0;
  localparam int O_IDLE = 1;
  localparam int O_AREF = 2;
  localparam int O_WR   = 3;
  localparam int O_RD   = 4;

  logic          clk = 1'b0;
  logic          Rst, Init_done, Aref_end, Wr_req, Rd_req, Wr_end, Rd_end;
  logic [3:0]    Init_cmd, Aref_cmd, Wr_cmd, Rd_cmd;
  logic [AW-1:0] Init_addr, Wr_addr, Rd_addr;
  logic [BW-1:0] Wr_bank, Rd_bank;
  logic          Aref_en, Wr_en, Rd_en, Aref_overrun;
  logic [3:0]    SDRAM_CMD;
  logic [AW-1:0] SDRAM_A_ADDR;
  logic [BW-1:0] SDRAM_BANK_ADDR;

  always #5 clk = ~clk;

  sdram_access_arbiter #(
    .SDRAM_ADDR_WIDTH(AW),
    .SDRAM_BANK_WIDTH(BW),
    .REF_PERIOD(RP)
  ) dut (
    .Sys_clk(clk), .Rst(Rst), .Init_done(Init_done), .Init_cmd(Init_cmd),
    .Init_addr(Init_addr), .Aref_end(Aref_end), .Aref_cmd(Aref_cmd),
    .Wr_req(Wr_req), .Rd_req(Rd_req), .Wr_end(Wr_end), .Rd_end(Rd_end),
    .Wr_cmd(Wr_cmd), .Rd_cmd(Rd_cmd), .Wr_addr(Wr_addr), .Rd_addr(Rd_addr),
    .Wr_bank(Wr_bank), .Rd_bank(Rd_bank), .Aref_en(Aref_en), .Wr_en(Wr_en),
    .Rd_en(Rd_en), .SDRAM_CMD(SDRAM_CMD), .SDRAM_A_ADDR(SDRAM_A_ADDR),
    .SDRAM_BANK_ADDR(SDRAM_BANK_ADDR), .Aref_overrun(Aref_overrun)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // behavioural model
  int m_owner = O_INIT;
  int m_timer = 0;
  bit m_pending = 1'b0;
  bit m_overrun = 1'b0;
  bit m_last_wr = 1'b0;

  // observation bookkeeping
  bit  p_ae = 1'b0, p_we = 1'b0, p_re = 1'b0;
  int  aref_rise = -1, wr_fall = -1, aref_rises = 0, wr_rises = 0, rd_rises = 0;
  byte grants[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [21:0] expected_outputs();
    logic [3:0]    cmd;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          ae, we, re;
    cmd = 4'b0111; a = '0; b = '0; ae = 1'b0; we = 1'b0; re = 1'b0;
    case (m_owner)
      O_INIT: begin cmd = Init_cmd; a = Init_addr; end
      O_AREF: begin ae = 1'b1; cmd = Aref_cmd; end
      O_WR:   begin we = 1'b1; cmd = Wr_cmd; a = Wr_addr; b = Wr_bank; end
      O_RD:   begin re = 1'b1; cmd = Rd_cmd; a = Rd_addr; b = Rd_bank; end
      default: ;
    endcase
    return {ae, we, re, cmd, a, b, m_overrun};
  endfunction

  task automatic model_tick();
    int nxt;
    bit expire;
    if (Rst) begin
      m_owner = O_INIT; m_timer = 0; m_pending = 1'b0;
      m_overrun = 1'b0; m_last_wr = 1'b0;
    end else begin
      nxt = m_owner;
      expire = 1'b0;
      if (m_owner != O_INIT || Init_done) begin
        expire  = (m_timer == RP - 1);
        m_timer = (m_timer + 1) % RP;
      end
      case (m_owner)
        O_INIT: if (Init_done) nxt = O_IDLE;
        O_IDLE: begin
          if (m_pending) nxt = O_AREF;
          else begin
`ifdef ARB_ROUND_ROBIN_EN
            if (Wr_req && Rd_req) nxt = m_last_wr ? O_RD : O_WR;
            else if (Wr_req)      nxt = O_WR;
            else if (Rd_req)      nxt = O_RD;
            if (nxt == O_WR) m_last_wr = 1'b1;
            if (nxt == O_RD) m_last_wr = 1'b0;
`else
            if (Rd_req)      nxt = O_RD;
            else if (Wr_req) nxt = O_WR;
`endif
          end
        end
        O_AREF: if (Aref_end) nxt = O_IDLE;
        O_WR:   if (Wr_end)   nxt = O_IDLE;
        O_RD:   if (Rd_end)   nxt = O_IDLE;
        default: nxt = O_INIT;
      endcase
      if (expire) begin
        if (m_pending) m_overrun = 1'b1;
        m_pending = 1'b1;
      end else if (m_owner == O_IDLE && nxt == O_AREF) begin
        m_pending = 1'b0;
      end
      m_owner = nxt;
    end
    cyc++;
  endtask

  // Randomize the engine buses, compare, then advance one clock.
  task automatic run_cycle();
    Init_cmd = 4'($urandom); Aref_cmd = 4'($urandom);
    Wr_cmd = 4'($urandom); Rd_cmd = 4'($urandom);
    Init_addr = AW'($urandom); Wr_addr = AW'($urandom); Rd_addr = AW'($urandom);
    Wr_bank = BW'($urandom); Rd_bank = BW'($urandom);
    #1;
    check_eq("outputs",
             {Aref_en, Wr_en, Rd_en, SDRAM_CMD, SDRAM_A_ADDR, SDRAM_BANK_ADDR, Aref_overrun},
             expected_outputs());
    if (Aref_en && !p_ae) begin aref_rise = cyc; aref_rises++; grants.push_back("A"); end
    if (Wr_en && !p_we) begin wr_rises++; grants.push_back("W"); end
    if (Rd_en && !p_re) begin rd_rises++; grants.push_back("R"); end
    if (!Wr_en && p_we) wr_fall = cyc;
    p_ae = Aref_en; p_we = Wr_en; p_re = Rd_en;
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic wait_aref(input int budget);
    int n0;
    n0 = aref_rises;
    for (int k = 0; k < budget && aref_rises == n0; k++) run_cycle();
  endtask

  task automatic wait_grant(input int budget);
    int n0;
    n0 = wr_rises + rd_rises;
    for (int k = 0; k < budget && (wr_rises + rd_rises) == n0; k++) run_cycle();
  endtask

  task automatic pulse_end(input int which);
    Aref_end = (which == O_AREF);
    Wr_end   = (which == O_WR);
    Rd_end   = (which == O_RD);
    run_cycle();
    Aref_end = 1'b0; Wr_end = 1'b0; Rd_end = 1'b0;
  endtask

  initial begin : stim
    int  left;
    int  prev_owner;
    int  n0;
    byte exp_g [3];

    Rst = 1'b1; Init_done = 1'b0; Aref_end = 1'b0; Wr_req = 1'b0; Rd_req = 1'b0;
    Wr_end = 1'b0; Rd_end = 1'b0;
    Init_cmd = '0; Aref_cmd = '0; Wr_cmd = '0; Rd_cmd = '0;
    Init_addr = '0; Wr_addr = '0; Rd_addr = '0; Wr_bank = '0; Rd_bank = '0;
    @(posedge clk);
    model_tick();
    @(negedge clk);

    // reset held, then INIT without Init_done
    repeat (3) run_cycle();
    Rst = 1'b0;
    repeat (2) run_cycle();

    // refresh cadence from Init_done at cycle 0
    cyc = 0;
    Init_done = 1'b1;
    wait_aref(2000);
    check_eq("first_aref_cycle", aref_rise, 781);
    repeat (9) run_cycle();
    pulse_end(O_AREF);
    check_eq("idle_after_aref", {Aref_en, SDRAM_CMD}, {1'b0, 4'b0111});
    wait_aref(2000);
    check_eq("second_aref_cycle", aref_rise, 1561);
    repeat (3) run_cycle();
    pulse_end(O_AREF);

    // tie between write and read
    grants.delete();
    Wr_req = 1'b1; Rd_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_grant(50);
      repeat (2) run_cycle();
      pulse_end(m_owner);
    end
    Wr_req = 1'b0; Rd_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g[0] = "W"; exp_g[1] = "R"; exp_g[2] = "W";
`else
    exp_g[0] = "R"; exp_g[1] = "R"; exp_g[2] = "R";
`endif
    for (int g = 0; g < 3; g++)
      check_eq($sformatf("tie_grant%0d", g), (grants.size() > g) ? grants[g] : 8'h3f, exp_g[g]);

    // refresh expiring during a write is deferred until Wr_end
    for (int k = 0; k < 800 && (cyc % RP) != 770; k++) run_cycle();
    Wr_req = 1'b1;
    wait_grant(20);
    Wr_req = 1'b0;
    for (int k = 0; k < 100 && (cyc % RP) != 10; k++) run_cycle();
    check_eq("wr_held_over_expiry", Wr_en, 1'b1);
    Rd_req = 1'b1;
    n0 = rd_rises;
    pulse_end(O_WR);
    wait_aref(20);
    check_eq("deferred_aref_gap", aref_rise - wr_fall, 1);
    check_eq("no_read_before_aref", rd_rises - n0, 0);
    Rd_req = 1'b0;
    repeat (3) run_cycle();
    pulse_end(O_AREF);
    repeat (2) run_cycle();

    // overrun: write held past two expiries
    Wr_req = 1'b1;
    wait_grant(20);
    Wr_req = 1'b0;
    repeat (1600) run_cycle();
    check_eq("overrun_set", Aref_overrun, 1'b1);
    pulse_end(O_WR);
    repeat (4) run_cycle();
    check_eq("overrun_sticky", {Aref_overrun, Aref_en}, 2'b11);
    pulse_end(O_AREF);

    // reset in the middle of a read
    Rd_req = 1'b1;
    wait_grant(20);
    Rd_req = 1'b0;
    repeat (3) run_cycle();
    Rst = 1'b1; Init_done = 1'b0;
    run_cycle();
    Rst = 1'b0;
    #1;
    check_eq("rd_en_after_rst", {Rd_en, Aref_overrun}, 2'b00);
    Rd_req = 1'b1;
    n0 = rd_rises;
    repeat (6) run_cycle();
    check_eq("no_grant_in_init", rd_rises - n0, 0);
    Init_done = 1'b1;
    wait_grant(10);
    check_eq("grant_after_init", rd_rises - n0, 1);
    Rd_req = 1'b0;
    pulse_end(O_RD);

    // randomized traffic
    left = 0;
    prev_owner = m_owner;
    for (int k = 0; k < 6000; k++) begin
      if (m_owner != prev_owner) left = $urandom_range(0, 12);
      prev_owner = m_owner;
      Rst = ($urandom_range(0, 1499) == 0);
      Init_done = (m_owner == O_INIT) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if ($urandom_range(0, 3) == 0) Wr_req = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) Rd_req = $urandom_range(0, 1);
      Aref_end = (m_owner == O_AREF && left == 0) || ($urandom_range(0, 19) == 0);
      Wr_end   = (m_owner == O_WR   && left == 0) || ($urandom_range(0, 19) == 0);
      Rd_end   = (m_owner == O_RD   && left == 0) || ($urandom_range(0, 19) == 0);
      if (left > 0) left--;
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
